// File: rtl/ex_stage_pkg.sv
// Shared operation codes, result classes and divider state encodings for the
// MIPS32 execute stage.
package ex_stage_pkg;

   localparam logic        RstEnable    = 1'b1;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;

   // Result classes (alusel)
   localparam logic [2:0] EXE_RES_NOP        = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
   localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
   localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
   localparam logic [2:0] EXE_RES_MUL        = 3'b101;

   // Operation subtypes (aluop)
   localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
   localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
   localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
   localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
   localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
   localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
   localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
   localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
   localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
   localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
   localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
   localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
   localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
   localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
   localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
   localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_ZERO = 2'b10,
      DIV_DONE = 2'b11
   } div_state_e;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? neg32(v) : v;
   endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; works on magnitudes and
// applies the sign fix-up when presenting the result.
module div_unit
   import ex_stage_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_div,
   input  logic        annul,
   input  logic [31:0] opdata1,
   input  logic [31:0] opdata2,
   output logic        ready,
   output logic        stall,
   output logic [63:0] result
);

   localparam int               CNT_W = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV_CYCLES - 1);

   div_state_e       state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [64:0]      work_reg, work_next;
   logic [31:0]      divisor_reg, divisor_next;
   logic             neg_q_reg, neg_q_next;
   logic             neg_r_reg, neg_r_next;
   logic [33:0]      trial, diff;
   logic [31:0]      q_abs, r_abs;

   // work_reg = {partial remainder (33b), dividend bits being replaced by quotient bits (32b)}
   assign trial = {work_reg[64:32], work_reg[31]};
   assign diff  = trial - {2'b00, divisor_reg};
   assign q_abs = work_reg[31:0];
   assign r_abs = work_reg[63:32];
   assign result = {neg_r_reg ? neg32(r_abs) : r_abs,
                    neg_q_reg ? neg32(q_abs) : q_abs};

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_reg   <= DIV_IDLE;
         count_reg   <= '0;
         work_reg    <= '0;
         divisor_reg <= ZeroWord;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         work_reg    <= work_next;
         divisor_reg <= divisor_next;
         neg_q_reg   <= neg_q_next;
         neg_r_reg   <= neg_r_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      work_next    = work_reg;
      divisor_next = divisor_reg;
      neg_q_next   = neg_q_reg;
      neg_r_next   = neg_r_reg;
      ready        = 1'b0;
      stall        = 1'b0;
      case (state_reg)
         DIV_IDLE: begin
            if (start) begin
               stall      = 1'b1;
               count_next = '0;
               if (opdata2 == ZeroWord) begin
                  state_next   = DIV_ZERO;
                  work_next    = '0;
                  divisor_next = ZeroWord;
                  neg_q_next   = 1'b0;
                  neg_r_next   = 1'b0;
               end else begin
                  state_next   = DIV_BUSY;
                  work_next    = {33'b0, abs32(opdata1, signed_div)};
                  divisor_next = abs32(opdata2, signed_div);
                  neg_q_next   = signed_div & (opdata1[31] ^ opdata2[31]);
                  neg_r_next   = signed_div & opdata1[31];
               end
            end
         end
         DIV_BUSY: begin
            stall = 1'b1;
            // Restoring step: keep the subtraction only if it did not go negative
            if (diff[33])
               work_next = {trial[32:0], work_reg[30:0], 1'b0};
            else
               work_next = {diff[32:0], work_reg[30:0], 1'b1};
            if (count_reg == LAST)
               state_next = DIV_DONE;
            else
               count_next = count_reg + CNT_W'(1);
         end
         DIV_ZERO: begin
            stall      = 1'b1;
            state_next = DIV_DONE;
         end
         DIV_DONE: begin
            ready      = 1'b1;
            state_next = DIV_IDLE;
         end
         default: state_next = DIV_IDLE;
      endcase
      if (annul) begin
         state_next = DIV_IDLE;
         ready      = 1'b0;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: single-cycle ALU/shift/compare/HI-LO/multiply result
// muxing with HI/LO forwarding, plus the stalling divider.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic        mem_whilo_i,
   input  logic [31:0] mem_hi_i,
   input  logic [31:0] mem_lo_i,
   input  logic        wb_whilo_i,
   input  logic [31:0] wb_hi_i,
   input  logic [31:0] wb_lo_i,
   input  logic        annul_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq_o
);

   logic [31:0] hi_fwd, lo_fwd;
   logic [31:0] logic_res, shift_res, arith_res, move_res, wdata_res;
   logic [31:0] sum_res, sub_res, sra_res;
   logic        ovf_add, ovf_sub, lt_signed, lt_unsigned;
   logic [63:0] prod_s, prod_u;
   logic        div_op, div_start, div_ready, div_stall;
   logic [63:0] div_result;

   // Youngest pending HI/LO write wins
   assign hi_fwd = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
   assign lo_fwd = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

   assign sum_res     = reg1_i + reg2_i;
   assign sub_res     = reg1_i - reg2_i;
   assign ovf_add     = (reg1_i[31] == reg2_i[31]) && (sum_res[31] != reg1_i[31]);
   assign ovf_sub     = (reg1_i[31] != reg2_i[31]) && (sub_res[31] != reg1_i[31]);
   assign lt_signed   = $signed(reg1_i) < $signed(reg2_i);
   assign lt_unsigned = reg1_i < reg2_i;
   assign sra_res     = $signed(reg2_i) >>> reg1_i[4:0];

   assign prod_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
   assign prod_u = {32'b0, reg1_i} * {32'b0, reg2_i};

   always_comb begin
      logic_res = ZeroWord;
      case (aluop_i)
         EXE_OR_OP:  logic_res = reg1_i | reg2_i;
         EXE_AND_OP: logic_res = reg1_i & reg2_i;
         EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
         EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
         default:    logic_res = ZeroWord;
      endcase
   end

   always_comb begin
      shift_res = ZeroWord;
      case (aluop_i)
         EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
         EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
         EXE_SRA_OP: shift_res = sra_res;
         default:    shift_res = ZeroWord;
      endcase
   end

   always_comb begin
      arith_res = ZeroWord;
      case (aluop_i)
         EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: arith_res = sum_res;
         EXE_SUB_OP, EXE_SUBU_OP: arith_res = sub_res;
         EXE_SLT_OP:              arith_res = {31'b0, lt_signed};
         EXE_SLTU_OP:             arith_res = {31'b0, lt_unsigned};
         default:                 arith_res = ZeroWord;
      endcase
   end

   always_comb begin
      move_res = ZeroWord;
      case (aluop_i)
         EXE_MFHI_OP:              move_res = hi_fwd;
         EXE_MFLO_OP:              move_res = lo_fwd;
         EXE_MOVN_OP, EXE_MOVZ_OP: move_res = reg1_i;
         default:                  move_res = ZeroWord;
      endcase
   end

   always_comb begin
      wdata_res = ZeroWord;
      case (alusel_i)
         EXE_RES_LOGIC:      wdata_res = logic_res;
         EXE_RES_SHIFT:      wdata_res = shift_res;
         EXE_RES_ARITHMETIC: wdata_res = arith_res;
         EXE_RES_MOVE:       wdata_res = move_res;
         EXE_RES_MUL:        wdata_res = prod_s[31:0];
         default:            wdata_res = ZeroWord;
      endcase
   end

   assign div_op    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
   assign div_start = div_op && !annul_i;

   div_unit #(
      .DIV_CYCLES(DIV_CYCLES)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .signed_div(aluop_i == EXE_DIV_OP),
      .annul     (annul_i),
      .opdata1   (reg1_i),
      .opdata2   (reg2_i),
      .ready     (div_ready),
      .stall     (div_stall),
      .result    (div_result)
   );

   always_comb begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = wdata_res;
      whilo_o    = WriteDisable;
      hi_o       = ZeroWord;
      lo_o       = ZeroWord;
      stallreq_o = div_stall;
      // Trapping add/sub still forwards the destination and data; only the write is dropped
      if (((aluop_i == EXE_ADD_OP || aluop_i == EXE_ADDI_OP) && ovf_add) ||
          (aluop_i == EXE_SUB_OP && ovf_sub))
         wreg_o = WriteDisable;
      case (aluop_i)
         EXE_MULT_OP: begin
            wreg_o  = WriteDisable;
            whilo_o = WriteEnable;
            hi_o    = prod_s[63:32];
            lo_o    = prod_s[31:0];
         end
         EXE_MULTU_OP: begin
            wreg_o  = WriteDisable;
            whilo_o = WriteEnable;
            hi_o    = prod_u[63:32];
            lo_o    = prod_u[31:0];
         end
         EXE_MTHI_OP: begin
            whilo_o = WriteEnable;
            hi_o    = reg1_i;
            lo_o    = lo_fwd;
         end
         EXE_MTLO_OP: begin
            whilo_o = WriteEnable;
            hi_o    = hi_fwd;
            lo_o    = reg1_i;
         end
         EXE_DIV_OP, EXE_DIVU_OP: begin
            if (div_ready) begin
               whilo_o = WriteEnable;
               hi_o    = div_result[63:32];
               lo_o    = div_result[31:0];
            end
         end
         default: ;
      endcase
      if (rst == RstEnable) begin
         wd_o       = 5'd0;
         wreg_o     = WriteDisable;
         wdata_o    = ZeroWord;
         whilo_o    = WriteDisable;
         hi_o       = ZeroWord;
         lo_o       = ZeroWord;
         stallreq_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized ops
// against an arithmetic reference model, and divider timing sequences.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] hi_i, lo_i;
   logic        mem_whilo_i, wb_whilo_i;
   logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
   logic        annul_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        whilo_o;
   logic [31:0] hi_o, lo_o;
   logic        stallreq_o;

   always #5 clk = ~clk;

   ex_stage #(.DIV_CYCLES(32)) dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .hi_i(hi_i), .lo_i(lo_i),
      .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
      .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
      .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [2:0]  sel;
      logic [31:0] a, b, hi;
      logic        wbw;
      logic [31:0] wbhi;
      logic        memw;
      logic [31:0] memhi;
      logic        ewreg;
      logic [31:0] ewdata;
      logic        chkwd;
      logic        ewhilo;
      logic [31:0] ehi, elo;
   } vec_t;

   typedef struct {
      logic        wreg;
      logic [31:0] wdata;
      logic        chkwd;
      logic        whilo;
      logic [31:0] hi, lo;
   } exp_t;

   // Reference model: MIPS semantics via wide integer arithmetic
   function automatic exp_t model(input logic [7:0] op, input logic [2:0] sel,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic wreg_in, input logic [31:0] hf,
                                  input logic [31:0] lf);
      exp_t e;
      longint sa, sb, r;
      longint unsigned ua, ub, ur;
      int n;
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      n  = int'(a[4:0]);
      e.wreg = wreg_in; e.wdata = 32'h0; e.whilo = 1'b0; e.hi = 32'h0; e.lo = 32'h0;
      e.chkwd = !(sel == EXE_RES_NOP || sel == EXE_RES_MUL);
      case (op)
         EXE_OR_OP:  e.wdata = a | b;
         EXE_AND_OP: e.wdata = a & b;
         EXE_XOR_OP: e.wdata = a ^ b;
         EXE_NOR_OP: e.wdata = ~(a | b);
         EXE_SLL_OP: e.wdata = b << n;
         EXE_SRL_OP: e.wdata = b >> n;
         EXE_SRA_OP: begin r = sb >>> n; e.wdata = r[31:0]; end
         EXE_ADD_OP, EXE_ADDI_OP, EXE_SUB_OP, EXE_ADDU_OP, EXE_ADDIU_OP, EXE_SUBU_OP: begin
            r = (op == EXE_SUB_OP || op == EXE_SUBU_OP) ? sa - sb : sa + sb;
            e.wdata = r[31:0];
            if ((op == EXE_ADD_OP || op == EXE_ADDI_OP || op == EXE_SUB_OP) &&
                (r > 64'sd2147483647 || r < -64'sd2147483648))
               e.wreg = 1'b0;
         end
         EXE_SLT_OP:  e.wdata = (sa < sb) ? 32'd1 : 32'd0;
         EXE_SLTU_OP: e.wdata = (ua < ub) ? 32'd1 : 32'd0;
         EXE_MFHI_OP: e.wdata = hf;
         EXE_MFLO_OP: e.wdata = lf;
         EXE_MOVN_OP, EXE_MOVZ_OP: e.wdata = a;
         EXE_MULT_OP: begin
            r = sa * sb; e.wreg = 1'b0; e.whilo = 1'b1; e.hi = r[63:32]; e.lo = r[31:0];
         end
         EXE_MULTU_OP: begin
            ur = ua * ub; e.wreg = 1'b0; e.whilo = 1'b1; e.hi = ur[63:32]; e.lo = ur[31:0];
         end
         EXE_MTHI_OP: begin e.whilo = 1'b1; e.hi = a; e.lo = lf; end
         EXE_MTLO_OP: begin e.whilo = 1'b1; e.hi = hf; e.lo = a; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic div_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] ehi, output logic [31:0] elo);
      longint q, r;
      if (b == 32'h0) begin
         ehi = 32'h0; elo = 32'h0;
      end else if (op == EXE_DIV_OP) begin
         q = longint'(int'(a)) / longint'(int'(b));
         r = longint'(int'(a)) % longint'(int'(b));
         ehi = r[31:0]; elo = q[31:0];
      end else begin
         q = longint'({32'b0, a}) / longint'({32'b0, b});
         r = longint'({32'b0, a}) % longint'({32'b0, b});
         ehi = r[31:0]; elo = q[31:0];
      end
   endtask

   task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b);
      aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, " wd"}, 32'(wd_o), 32'(wd_i));
      chk({tag, " wreg"}, 32'(wreg_o), 32'(e.wreg));
      if (e.chkwd) chk({tag, " wdata"}, wdata_o, e.wdata);
      chk({tag, " whilo"}, 32'(whilo_o), 32'(e.whilo));
      chk({tag, " hi"}, hi_o, e.hi);
      chk({tag, " lo"}, lo_o, e.lo);
      chk({tag, " stall"}, 32'(stallreq_o), 32'd0);
   endtask

   // Presents a divide one cycle after the previous call returned and holds it until DONE
   task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall);
      int n;
      logic early;
      logic [31:0] ehi, elo;
      div_model(op, a, b, ehi, elo);
      @(negedge clk);
      set_op(op, EXE_RES_NOP, a, b);
      wreg_i = 1'b0;
      #2;
      n = 0; early = 1'b0;
      while (stallreq_o === 1'b1 && n < 100) begin
         n++;
         if (whilo_o !== 1'b0) early = 1'b1;
         @(negedge clk);
         #2;
      end
      chk({tag, " stall cycles"}, 32'(n), 32'(exp_stall));
      chk({tag, " whilo while stalled"}, 32'(early), 32'd0);
      chk({tag, " done whilo"}, 32'(whilo_o), 32'd1);
      chk({tag, " done hi"}, hi_o, ehi);
      chk({tag, " done lo"}, lo_o, elo);
      $display("div %s a=%h b=%h stall=%0d hi=%h lo=%h", tag, a, b, n, hi_o, lo_o);
   endtask

   // Starts a DIV, disturbs it at N+10 with annul or reset, then expects silence
   task automatic abort_div(input string tag, input logic use_rst);
      int n;
      logic seen;
      @(negedge clk);
      set_op(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3);
      #2 chk({tag, " stall at N"}, 32'(stallreq_o), 32'd1);
      repeat (9) @(negedge clk);
      #2 chk({tag, " stall at N+9"}, 32'(stallreq_o), 32'd1);
      @(negedge clk);
      if (use_rst) rst = 1'b1; else annul_i = 1'b1;
      #2;
      if (use_rst) chk({tag, " stall in reset"}, 32'(stallreq_o), 32'd0);
      else         chk({tag, " stall at annul"}, 32'(stallreq_o), 32'd1);
      @(negedge clk);
      rst = 1'b0; annul_i = 1'b0;
      set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
      #2;
      chk({tag, " stall at N+11"}, 32'(stallreq_o), 32'd0);
      seen = 1'b0;
      for (n = 0; n < 40; n++) begin
         if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) seen = 1'b1;
         @(negedge clk);
         #2;
      end
      chk({tag, " no hilo write after abort"}, 32'(seen), 32'd0);
      $display("abort %s done", tag);
   endtask

   vec_t vecs[17];
   logic [7:0] rops[23];
   logic [2:0] rsels[23];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [31:0] hf, lf;
      int k;

      vecs[0]  = '{EXE_ADD_OP,  EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h80000000, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[1]  = '{EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80000000, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[2]  = '{EXE_SRA_OP,  EXE_RES_SHIFT, 32'h4, 32'h80000000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hF8000000, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[3]  = '{EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[4]  = '{EXE_SLT_OP,  EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[5]  = '{EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 32'h1, 1'b1, 32'h2, 1'b1, 32'h3, 1'b1, 32'h3, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[6]  = '{EXE_MULT_OP, EXE_RES_MUL, 32'hFFFFFFFF, 32'h2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[7]  = '{EXE_MULTU_OP, EXE_RES_MUL, 32'hFFFFFFFF, 32'h2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1, 32'hFFFFFFFE};
      vecs[8]  = '{EXE_MTHI_OP, EXE_RES_NOP, 32'hABCD, 32'h0, 32'h0, 1'b1, 32'h2, 1'b0, 32'h3, 1'b1, 32'h0, 1'b0, 1'b1, 32'hABCD, 32'h20};
      vecs[9]  = '{EXE_MTLO_OP, EXE_RES_NOP, 32'h55, 32'h0, 32'h1, 1'b1, 32'h2, 1'b1, 32'h3, 1'b1, 32'h0, 1'b0, 1'b1, 32'h3, 32'h55};
      vecs[10] = '{EXE_SUB_OP,  EXE_RES_ARITHMETIC, 32'h80000000, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[11] = '{EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[12] = '{EXE_ADD_OP,  3'b111, 32'h5, 32'h6, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[13] = '{EXE_MOVN_OP, EXE_RES_MOVE, 32'h1234, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[14] = '{EXE_SLL_OP,  EXE_RES_SHIFT, 32'h1F, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80000000, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[15] = '{EXE_SRL_OP,  EXE_RES_SHIFT, 32'h8, 32'h80000000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h00800000, 1'b1, 1'b0, 32'h0, 32'h0};
      vecs[16] = '{EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 32'h0, 1'b1, 32'h2, 1'b0, 32'h3, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 32'h0};

      rops = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
               EXE_SRA_OP, EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP, EXE_SUB_OP,
               EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_MFHI_OP, EXE_MFLO_OP, EXE_MOVN_OP,
               EXE_MOVZ_OP, EXE_MULT_OP, EXE_MULTU_OP, EXE_MTHI_OP, EXE_MTLO_OP};
      rsels = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT,
                EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC,
                EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC,
                EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_MOVE,
                EXE_RES_MOVE, EXE_RES_MUL, EXE_RES_MUL, EXE_RES_NOP, EXE_RES_NOP};

      // Reset: every output held at zero regardless of inputs
      rst = 1'b1; annul_i = 1'b0;
      wd_i = 5'd9; wreg_i = 1'b1;
      hi_i = 32'h1; lo_i = 32'h10;
      wb_whilo_i = 1'b1; wb_hi_i = 32'h2; wb_lo_i = 32'h20;
      mem_whilo_i = 1'b1; mem_hi_i = 32'h3; mem_lo_i = 32'h30;
      set_op(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h1234, 32'h1);
      @(negedge clk); #2;
      chk("reset wd", 32'(wd_o), 32'd0);
      chk("reset wreg", 32'(wreg_o), 32'd0);
      chk("reset wdata", wdata_o, 32'd0);
      set_op(EXE_MTHI_OP, EXE_RES_NOP, 32'hDEAD, 32'h0);
      @(negedge clk); #2;
      chk("reset whilo", 32'(whilo_o), 32'd0);
      chk("reset hi", hi_o, 32'd0);
      chk("reset lo", lo_o, 32'd0);
      set_op(EXE_DIV_OP, EXE_RES_NOP, 32'd7, 32'd2);
      @(negedge clk); #2;
      chk("reset stall", 32'(stallreq_o), 32'd0);
      $display("reset checks done");
      @(negedge clk);
      rst = 1'b0;
      set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);

      // Directed vector table
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         set_op(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b);
         wreg_i = 1'b1; wd_i = 5'(i + 1);
         hi_i = vecs[i].hi; lo_i = 32'h10;
         wb_whilo_i = vecs[i].wbw; wb_hi_i = vecs[i].wbhi; wb_lo_i = 32'h20;
         mem_whilo_i = vecs[i].memw; mem_hi_i = vecs[i].memhi; mem_lo_i = 32'h30;
         #2;
         e.wreg = vecs[i].ewreg; e.wdata = vecs[i].ewdata; e.chkwd = vecs[i].chkwd;
         e.whilo = vecs[i].ewhilo; e.hi = vecs[i].ehi; e.lo = vecs[i].elo;
         check_all($sformatf("vec%0d", i), e);
         $display("vec %0d op=%h a=%h b=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, wreg_o, wdata_o, whilo_o, hi_o, lo_o);
      end

      // Randomized single-cycle ops against the reference model
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         k = int'($urandom_range(0, 22));
         set_op(rops[k], rsels[k], $urandom, $urandom);
         case ($urandom_range(0, 5))
            0: reg1_i = 32'h7FFFFFFF;
            1: reg2_i = 32'h80000000;
            2: reg2_i = 32'hFFFFFFFF;
            default: ;
         endcase
         wreg_i = 1'($urandom); wd_i = 5'($urandom);
         hi_i = $urandom; lo_i = $urandom;
         wb_whilo_i = 1'($urandom); wb_hi_i = $urandom; wb_lo_i = $urandom;
         mem_whilo_i = 1'($urandom); mem_hi_i = $urandom; mem_lo_i = $urandom;
         hf = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
         lf = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
         e = model(aluop_i, alusel_i, reg1_i, reg2_i, wreg_i, hf, lf);
         #2;
         check_all($sformatf("rnd%0d op=%h a=%h b=%h", i, aluop_i, reg1_i, reg2_i), e);
         $display("rnd %0d op=%h a=%h b=%h wdata=%h hi=%h lo=%h", i, aluop_i, reg1_i, reg2_i,
                  wdata_o, hi_o, lo_o);
      end

      // Divider: directed, zero divisor, back-to-back randomized
      @(negedge clk);
      set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
      mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;
      run_div("div -7/2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 33);
      run_div("divu 7/0", EXE_DIVU_OP, 32'd7, 32'd0, 2);
      run_div("div min/-1", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 33);
      for (int i = 0; i < 5; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = (i == 2) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
         if (i == 4) rb = 32'h0000_0001 | rb;
         run_div($sformatf("rdiv%0d", i), (i % 2 == 0) ? EXE_DIV_OP : EXE_DIVU_OP, ra, rb,
                 (rb == 32'h0) ? 2 : 33);
      end
      @(negedge clk);
      set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
      #2;
      chk("after div stall", 32'(stallreq_o), 32'd0);
      chk("after div whilo", 32'(whilo_o), 32'd0);

      abort_div("annul", 1'b0);
      abort_div("reset", 1'b1);
      run_div("divu after abort", EXE_DIVU_OP, 32'd100, 32'd7, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS32 integer pipeline. Sits between the ID/EX and EX/MEM pipeline registers and consumes the decoded operation (`aluop`/`alusel`), operands, destination and write-enable produced by decode. Computes logic, shift, arithmetic, compare, HI/LO-move and multiply results in a single cycle. DIV/DIVU runs on an embedded multi-cycle divider that holds the pipeline via `stallreq_o`.

## Interface
Parameters:
- `DIV_CYCLES`, 32: radix-2 iterations per division; fixed at 32 for MIPS32.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `aluop_i`  in  8  operation subtype (shared `EXE_*_OP` codes)
- `alusel_i`  in  3  result class (shared `EXE_RES_*` codes)
- `reg1_i`, `reg2_i`  in  32  operands; already forwarded, or already immediate-substituted
- `wd_i`  in  5  destination register
- `wreg_i`  in  1  register write enable
- `hi_i`, `lo_i`  in  32  architectural HI/LO
- `mem_whilo_i`, `mem_hi_i`, `mem_lo_i`  in  1/32/32  HI/LO write pending in MEM
- `wb_whilo_i`, `wb_hi_i`, `wb_lo_i`  in  1/32/32  HI/LO write pending in WB
- `annul_i`  in  1  flush; aborts any division in progress
- `wd_o`  out  5  destination register
- `wreg_o`  out  1  register write enable
- `wdata_o`  out  32  register write data
- `whilo_o`  out  1  HI/LO write enable
- `hi_o`, `lo_o`  out  32  HI/LO write data
- `stallreq_o`  out  1  stall request to pipeline control

## Operation
- `rst`: all outputs 0, divider FSM → IDLE, divider registers cleared.
- HI/LO source priority for reads: MEM, then WB, then `hi_i`/`lo_i`.
- LOGIC: OR, AND, XOR, NOR on `reg1_i`/`reg2_i`.
- SHIFT: SLL, SRL, SRA. Shifts `reg2_i` by `reg1_i[4:0]`. SRA is arithmetic.
- ARITHMETIC:
  - ADD/ADDI/SUB: on signed overflow, `wreg_o`=0; `wd_o` and `wdata_o` still pass through.
  - ADDU/ADDIU/SUBU: no overflow check.
  - SLT: signed compare, result 0/1. SLTU: unsigned compare, result 0/1.
- HILO class:
  - MFHI/MFLO: `wdata_o` = forwarded HI/LO.
  - MTHI: `whilo_o`=1, `hi_o`=`reg1_i`, `lo_o`=forwarded LO.
  - MTLO: `whilo_o`=1, `lo_o`=`reg1_i`, `hi_o`=forwarded HI.
  - MOVN/MOVZ: `wdata_o`=`reg1_i`; `wreg_i` is taken as-is from decode.
- MUL class:
  - MULT: signed 64-bit product. MULTU: unsigned 64-bit product.
  - `{hi_o,lo_o}`=product, `whilo_o`=1, `wreg_o` forced 0.
- Unknown `alusel_i`: `wdata_o`=0.
- Division, handled in sub-module `div_unit`:
  - Operates on absolute values.
  - Signed fix-up: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Result: `lo_o`=quotient, `hi_o`=remainder, `whilo_o`=1 in the DONE cycle only.
  - Divide-by-zero: result is HI=0, LO=0.
- Divider FSM:
  - IDLE → ZERO when a DIV/DIVU op is present and `reg2_i`==0.
  - IDLE → BUSY when a DIV/DIVU op is present and `reg2_i`≠0; operands latched.
  - BUSY: counts 0..31, one restoring subtract-shift per cycle; at count 31 → DONE.
  - ZERO → DONE.
  - DONE → IDLE.
  - `annul_i` in any state → IDLE next cycle; no HI/LO write occurs.
- Subsequent DIV ops are accepted only in IDLE. DONE's return to IDLE prevents the still-present stalled op from restarting.

## Timing
- All non-divide results are combinational from the inputs in the same cycle; no added latency.
- DIV presented in cycle N (nonzero divisor):
  - `stallreq_o`=1 for cycles N..N+32.
  - DONE in cycle N+33: `stallreq_o`=0, `whilo_o`=1.
- DIV with zero divisor: `stallreq_o`=1 in N and N+1; DONE in N+2.
- `stallreq_o` is combinational from FSM state plus the op decode: high in IDLE when a DIV op is present, high in BUSY/ZERO, low in DONE.
- `rst` or `annul_i` asserted mid-division: `stallreq_o`=0 and FSM=IDLE the following cycle.
- Back-to-back DIVs: the second is accepted in the cycle after DONE.

## Structure
- Shared defines file holds `EXE_*_OP`, `EXE_RES_*`, `ZeroWord`, `RstEnable`, `WriteEnable`/`WriteDisable`, and the divider state encodings.
- One sub-module, `div_unit`: sign handling, FSM, 65-bit working register, `start`/`signed`/`annul` inputs, `ready`/`result` outputs.
- `ex_stage` holds the result muxing and HI/LO forwarding.

## Test plan
- ADD 0x7FFFFFFF+1 → `wreg_o`=0. ADDU of the same operands → `wdata_o`=0x80000000, `wreg_o`=1.
- SRA `reg2`=0x80000000, shift 4 → 0xF8000000. SLTU 0xFFFFFFFF vs 1 → 0. SLT of the same operands → 1.
- MFHI with `hi_i`=1, `wb_hi_i`=2 (WB write pending), `mem_hi_i`=3 (MEM write pending) → `wdata_o`=3.
- MULT 0xFFFFFFFF×2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU of the same operands → HI=1, LO=0xFFFFFFFE.
- DIV −7/2 held under stall → stall for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFD. DIVU 7/0 → DONE at N+2 with HI=LO=0.
- DIV started, `annul_i` at cycle N+10 → `stallreq_o`=0 at N+11, no `whilo_o` pulse; `rst` mid-BUSY behaves the same.
